// File: rtl/hdd_sd_bridge.sv
// Storage-side responder for the ProDOS HDD card: turns one-cycle block
// read/write requests into the MiSTer host block-transfer handshake.
module hdd_sd_bridge #(
  parameter logic [31:0] LBA_BASE = 32'h0,
  parameter logic [23:0] TIMEOUT  = 24'd14_000_000
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] sector,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_di,
  output logic        buf_we,
  input  logic [7:0]  buf_do,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [23:0] TMO_LAST   = TIMEOUT - 24'd1;
  localparam logic [9:0]  FULL_BLOCK = 10'd512;
  localparam logic [9:0]  CNT_MAX    = 10'h3FF;

  logic [1:0]  state_q, state_d;
  logic        op_write_q, op_write_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        overrun_q, overrun_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  logic in_xfer;
  logic req_any;
  logic xfer_we;

  assign in_xfer = (state_q == S_XFER);
  assign req_any = hdd_read | hdd_write;
  assign xfer_we = in_xfer & ~op_write_q & sd_ack & sd_buff_wr;

  // Buffer port is a zero-latency pass-through of the host bus while
  // transferring and parked at zero otherwise.
  always_comb begin
    buf_addr    = 9'd0;
    buf_di      = 8'd0;
    buf_we      = 1'b0;
    sd_buff_din = 8'd0;
    if (in_xfer) begin
      buf_addr = sd_buff_addr;
      if (op_write_q) begin
        sd_buff_din = buf_do;
      end else begin
        buf_di = sd_buff_dout;
        buf_we = xfer_we;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    overrun_d  = 1'b0;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          // Simultaneous pulses: the read is served, the write is reported dropped.
          op_write_d = ~hdd_read;
          sd_lba_d   = LBA_BASE + {16'h0, sector};
          sd_rd_d    = hdd_read;
          sd_wr_d    = ~hdd_read;
          error_d    = 1'b0;
          byte_cnt_d = 10'd0;
          tmo_cnt_d  = 24'd0;
          busy_d     = 1'b1;
          overrun_d  = hdd_read & hdd_write;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        overrun_d = req_any;
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_XFER;
        end else if (tmo_cnt_q == TMO_LAST) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      S_XFER: begin
        overrun_d = req_any;
        // Saturate so a runaway host can never wrap back to a "full" count.
        if (xfer_we && (byte_cnt_q != CNT_MAX)) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
        end
        if (!sd_ack) begin
          if (!op_write_q && (byte_cnt_q != FULL_BLOCK)) begin
            error_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        overrun_d = req_any;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      sd_lba_q   <= 32'h0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
      byte_cnt_q <= 10'd0;
      tmo_cnt_q  <= 24'd0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      overrun_q  <= overrun_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign sd_lba  = sd_lba_q;
  assign sd_rd   = sd_rd_q;
  assign sd_wr   = sd_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Directed bench for hdd_sd_bridge: a host handshake driver plus a
// registered-read sector buffer model, with hand-computed expectations.
module tb_hdd_sd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdd_read = 1'b0;
  logic        hdd_write = 1'b0;
  logic [15:0] sector = 16'h0;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  buf_do = 8'd0;

  logic [8:0]  a_buf_addr, b_buf_addr;
  logic [7:0]  a_buf_di, b_buf_di;
  logic        a_buf_we, b_buf_we;
  logic [31:0] a_sd_lba, b_sd_lba;
  logic        a_sd_rd, b_sd_rd;
  logic        a_sd_wr, b_sd_wr;
  logic [7:0]  a_sd_buff_din, b_sd_buff_din;
  logic        a_busy, b_busy;
  logic        a_done, b_done;
  logic        a_error, b_error;
  logic        a_overrun, b_overrun;

  logic [7:0] mem [0:511];
  int we_cnt = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hdd_sd_bridge #(.LBA_BASE(32'h0), .TIMEOUT(24'd100)) dut_a (
    .CLK_14M(clk), .RESET(rst), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .sector(sector), .buf_addr(a_buf_addr), .buf_di(a_buf_di), .buf_we(a_buf_we),
    .buf_do(buf_do), .sd_lba(a_sd_lba), .sd_rd(a_sd_rd), .sd_wr(a_sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(a_sd_buff_din), .sd_buff_wr(sd_buff_wr), .busy(a_busy),
    .done(a_done), .error(a_error), .overrun(a_overrun)
  );

  // Second instance only exercises the LBA wrap with a large base.
  hdd_sd_bridge #(.LBA_BASE(32'hFFFF_0001), .TIMEOUT(24'd100)) dut_b (
    .CLK_14M(clk), .RESET(rst), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .sector(sector), .buf_addr(b_buf_addr), .buf_di(b_buf_di), .buf_we(b_buf_we),
    .buf_do(buf_do), .sd_lba(b_sd_lba), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(b_sd_buff_din), .sd_buff_wr(sd_buff_wr), .busy(b_busy),
    .done(b_done), .error(b_error), .overrun(b_overrun)
  );

  always @(posedge clk) begin
    if (a_buf_we) mem[a_buf_addr] <= a_buf_di;
    buf_do <= mem[a_buf_addr];
    if (a_buf_we) we_cnt <= we_cnt + 1;
    if (a_done) done_cnt <= done_cnt + 1;
    if (a_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic rd, input logic wr, input logic [15:0] s);
    hdd_read = rd;
    hdd_write = wr;
    sector = s;
    step;
    hdd_read = 1'b0;
    hdd_write = 1'b0;
  endtask

  task automatic strobe_bytes(input int first, input int n, input logic [7:0] x);
    for (int i = first; i < first + n; i++) begin
      logic [8:0] a;
      a = i[8:0];
      sd_buff_addr = a;
      sd_buff_dout = a[7:0] ^ x;
      sd_buff_wr = 1'b1;
      step;
    end
    sd_buff_wr = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input logic exp_err);
    sd_ack = 1'b0;
    step;
    chk({tag, "_done"}, a_done, 1'b1);
    chk({tag, "_busy_in_done"}, a_busy, 1'b1);
    chk({tag, "_error"}, a_error, exp_err);
    step;
    chk({tag, "_done_drop"}, a_done, 1'b0);
    chk({tag, "_busy_drop"}, a_busy, 1'b0);
    $display("cmd %s complete: error=%0d", tag, a_error);
  endtask

  task automatic chk_buf(input string tag, input logic [7:0] x);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] a;
      a = i[8:0];
      if (mem[i] !== (a[7:0] ^ x)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int w0;
    int o0;
    int k;
    int bad;

    step;
    step;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rd", a_sd_rd, 1'b0);
    chk("rst_wr", a_sd_wr, 1'b0);
    chk("rst_lba", a_sd_lba, 32'h0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err", a_error, 1'b0);
    chk("rst_ovr", a_overrun, 1'b0);
    chk("rst_we", a_buf_we, 1'b0);
    chk("rst_addr", a_buf_addr, 9'd0);
    chk("rst_din", a_sd_buff_din, 8'd0);
    rst = 1'b0;
    step;

    // Full read of block 0x0123, host pattern = index
    w0 = we_cnt;
    pulse(1'b1, 1'b0, 16'h0123);
    chk("rd_lba", a_sd_lba, 32'h0000_0123);
    chk("rd_sd_rd", a_sd_rd, 1'b1);
    chk("rd_busy", a_busy, 1'b1);
    step;
    step;
    chk("rd_held", a_sd_rd, 1'b1);
    sd_ack = 1'b1;
    step;
    chk("rd_drop", a_sd_rd, 1'b0);
    strobe_bytes(0, 5, 8'h00);
    sd_buff_addr = 9'd5;
    sd_buff_dout = 8'h05;
    sd_buff_wr = 1'b1;
    #1;
    chk("pt_we", a_buf_we, 1'b1);
    chk("pt_addr", a_buf_addr, 9'd5);
    chk("pt_di", a_buf_di, 8'h05);
    step;
    sd_buff_wr = 1'b0;
    strobe_bytes(6, 506, 8'h00);
    finish_cmd("read", 1'b0);
    chk("rd_we_count", we_cnt - w0, 512);
    chk_buf("rd_pattern", 8'h00);

    // Timeout: no ack, 100 REQ cycles
    pulse(1'b1, 1'b0, 16'h0010);
    k = 0;
    while (a_sd_rd && k < 200) begin
      step;
      k++;
    end
    chk("tmo_cycles", k, 100);
    chk("tmo_done", a_done, 1'b1);
    chk("tmo_error", a_error, 1'b1);
    step;
    chk("tmo_busy", a_busy, 1'b0);
    chk("tmo_err_sticky", a_error, 1'b1);
    $display("cmd timeout complete: req cycles=%0d", k);

    // Short read: 300 bytes
    pulse(1'b1, 1'b0, 16'h0020);
    chk("short_err_clr", a_error, 1'b0);
    sd_ack = 1'b1;
    step;
    strobe_bytes(0, 300, 8'h00);
    finish_cmd("short", 1'b1);

    // Write pulse during read XFER is dropped
    o0 = ovr_cnt;
    pulse(1'b1, 1'b0, 16'h0042);
    sd_ack = 1'b1;
    step;
    strobe_bytes(0, 10, 8'h5A);
    hdd_write = 1'b1;
    sector = 16'h0999;
    strobe_bytes(10, 1, 8'h5A);
    hdd_write = 1'b0;
    chk("ovr_pulse", a_overrun, 1'b1);
    strobe_bytes(11, 1, 8'h5A);
    chk("ovr_one_cycle", a_overrun, 1'b0);
    chk("ovr_lba", a_sd_lba, 32'h0000_0042);
    chk("ovr_no_wr", a_sd_wr, 1'b0);
    strobe_bytes(12, 500, 8'h5A);
    finish_cmd("ovr_read", 1'b0);
    chk("ovr_count", ovr_cnt - o0, 1);

    // Simultaneous read+write in IDLE: read wins
    pulse(1'b1, 1'b1, 16'h0005);
    chk("sim_rd", a_sd_rd, 1'b1);
    chk("sim_wr", a_sd_wr, 1'b0);
    chk("sim_ovr", a_overrun, 1'b1);
    chk("sim_lba", a_sd_lba, 32'h0000_0005);
    sd_ack = 1'b1;
    step;
    strobe_bytes(0, 512, 8'h5A);
    finish_cmd("sim_read", 1'b0);

    // Reset after 100 bytes, with ack and strobe still asserted
    pulse(1'b1, 1'b0, 16'h0077);
    sd_ack = 1'b1;
    step;
    strobe_bytes(0, 100, 8'h5A);
    sd_buff_wr = 1'b1;
    rst = 1'b1;
    step;
    chk("mrst_busy", a_busy, 1'b0);
    chk("mrst_rd", a_sd_rd, 1'b0);
    chk("mrst_wr", a_sd_wr, 1'b0);
    chk("mrst_we", a_buf_we, 1'b0);
    rst = 1'b0;
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    step;
    $display("cmd reset mid-xfer applied");
    w0 = we_cnt;
    pulse(1'b1, 1'b0, 16'h0078);
    sd_ack = 1'b1;
    step;
    strobe_bytes(0, 512, 8'h5A);
    finish_cmd("post_rst", 1'b0);
    chk("post_rst_we", we_cnt - w0, 512);
    chk_buf("post_rst_pattern", 8'h5A);

    // Write block 0xFFFF; instance b wraps the LBA to 0
    w0 = we_cnt;
    pulse(1'b0, 1'b1, 16'hFFFF);
    chk("wr_lba_a", a_sd_lba, 32'h0000_FFFF);
    chk("wr_lba_wrap", b_sd_lba, 32'h0000_0000);
    chk("wr_sd_wr", a_sd_wr, 1'b1);
    chk("wr_sd_wr_b", b_sd_wr, 1'b1);
    chk("wr_sd_rd", a_sd_rd, 1'b0);
    sd_ack = 1'b1;
    step;
    chk("wr_drop", a_sd_wr, 1'b0);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] a;
      a = i[8:0];
      sd_buff_addr = a;
      step;
      if (a_sd_buff_din !== (a[7:0] ^ 8'h5A)) bad++;
      if (i == 300) chk("wr_din_300", a_sd_buff_din, 8'h2C ^ 8'h5A);
    end
    chk("wr_din_sweep", bad, 0);
    finish_cmd("write", 1'b0);
    chk("wr_no_we", we_cnt - w0, 0);
    chk("done_total", done_cnt, 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
